native_regbank: RTL

//  Register bank on the native side of the AXI4-Lite-to-native bridge. Consumes the

---
 rtl/native_regbank_pkg.sv | 40 ++++
 rtl/native_read_pipe.sv | 61 ++++++
 rtl/native_regbank.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/native_regbank_pkg.sv
// native_regbank_pkg
//   Shared definitions for the native-side register bank: the value returned
//   for unmapped reads, the register-index layout helpers and the region enum
//   used by the address decoder.
//   Layout (register indices, relative to BASE_ADDR >> 2):
//     0 .. num_ctrl-1                 CTRL      (RW)
//     num_ctrl .. +num_status-1       STATUS    (RO)
//     num_ctrl+num_status             WCOUNT    (RO)
//     +1 / +2                         IRQ_STAT (W1C) / IRQ_MASK (RW),
//                                     present only with NATIVE_REGBANK_IRQ_EN
package native_regbank_pkg;

  localparam logic [31:0] UNMAPPED_VALUE = 32'hDEADC0DE;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_STATUS,
    REG_WCOUNT,
    REG_IRQ_STAT,
    REG_IRQ_MASK,
    REG_NONE
  } region_e;

  function automatic int status_base(input int num_ctrl);
    return num_ctrl;
  endfunction

  function automatic int wcount_idx(input int num_ctrl, input int num_status);
    return num_ctrl + num_status;
  endfunction

  function automatic int irq_stat_idx(input int num_ctrl, input int num_status);
    return num_ctrl + num_status + 1;
  endfunction

  function automatic int irq_mask_idx(input int num_ctrl, input int num_status);
    return num_ctrl + num_status + 2;
  endfunction

endpackage

// File: rtl/native_read_pipe.sv
// native_read_pipe
//   LATENCY-deep delay line for read responses. A push enters stage 0 at the
//   next edge and leaves the last stage LATENCY cycles after the push cycle.
//   Each stage only reloads its data when the stage before it holds a valid
//   entry, so the output data holds its last value between valid pulses.
//   Reset clears every stage, dropping anything in flight.
// Ports
//   clk        in   1            clock
//   srst       in   1            synchronous active-high reset
//   push       in   1            new entry this cycle
//   push_data  in   DATA_WIDTH   data of the new entry
//   valid      out  1            one-cycle pulse per entry at the pipe end
//   data       out  DATA_WIDTH   data at the pipe end
module native_read_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  valid_reg    [LATENCY];
  logic [DATA_WIDTH-1:0] data_reg     [LATENCY];
  logic                  stage_valid  [LATENCY];
  logic [DATA_WIDTH-1:0] stage_data   [LATENCY];

  // Input of each stage: the push port for stage 0, the previous stage otherwise.
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage_in
    if (gi == 0) begin : g_first
      assign stage_valid[gi] = push;
      assign stage_data[gi]  = push_data;
    end else begin : g_rest
      assign stage_valid[gi] = valid_reg[gi-1];
      assign stage_data[gi]  = data_reg[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_reg[i] <= 1'b0;
        data_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_reg[i] <= stage_valid[i];
        if (stage_valid[i]) begin
          data_reg[i] <= stage_data[i];
        end
      end
    end
  end

  assign valid = valid_reg[LATENCY-1];
  assign data  = data_reg[LATENCY-1];

endmodule

// File: rtl/native_regbank.sv
// native_regbank
//   Register bank on the native side of the AXI4-Lite-to-native bridge.
//   Holds RW control registers, exposes sampled RO status words and a
//   write-completion counter (WCOUNT, counts WACK pulses, wraps).
//   Reads are sampled in the REN cycle and returned READ_LATENCY cycles later.
//   Optional feature macro: NATIVE_REGBANK_IRQ_EN adds IRQ_STAT (W1C, set on
//   rising edges of IRQ_SRC) and IRQ_MASK (RW), and drives IRQ registered.
//   Without it those indices are unmapped, IRQ_SRC is ignored, IRQ is 0.
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   WEN/WADDR/WDATA   write strobe, byte address, data
//   WACK              bridge write-response-accepted pulse (counted in WCOUNT)
//   REN/RADDR         read strobe, byte address
//   RDATA/RVALID      read data and its one-cycle valid pulse
//   CTRL_OUT          control registers, flat, reg i at [i*DW +: DW]
//   WR_STROBE         per-control-register pulse, the cycle after a write
//   STATUS_IN         status words, flat
//   IRQ_SRC/IRQ       interrupt sources / registered interrupt request
module native_regbank
  import native_regbank_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int unsigned           NUM_CTRL     = 8,
  parameter int unsigned           NUM_STATUS   = 4,
  parameter int unsigned           READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] CTRL_RST_VAL = '0
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             WEN,
  input  logic [ADDR_WIDTH-1:0]            WADDR,
  input  logic [DATA_WIDTH-1:0]            WDATA,
  input  logic                             WACK,
  input  logic                             REN,
  input  logic [ADDR_WIDTH-1:0]            RADDR,
  output logic [DATA_WIDTH-1:0]            RDATA,
  output logic                             RVALID,
  output logic [NUM_CTRL*DATA_WIDTH-1:0]   CTRL_OUT,
  output logic [NUM_CTRL-1:0]              WR_STROBE,
  input  logic [NUM_STATUS*DATA_WIDTH-1:0] STATUS_IN,
  input  logic [DATA_WIDTH-1:0]            IRQ_SRC,
  output logic                             IRQ
);

  // Region of a register index; below_base marks addresses under BASE_ADDR.
  function automatic region_e region_of(input logic below_base,
                                        input logic [ADDR_WIDTH-1:0] idx);
    region_e r;
    r = REG_NONE;
    if (!below_base) begin
      if (idx < ADDR_WIDTH'(status_base(NUM_CTRL))) begin
        r = REG_CTRL;
      end else if (idx < ADDR_WIDTH'(wcount_idx(NUM_CTRL, NUM_STATUS))) begin
        r = REG_STATUS;
      end else if (idx == ADDR_WIDTH'(wcount_idx(NUM_CTRL, NUM_STATUS))) begin
        r = REG_WCOUNT;
`ifdef NATIVE_REGBANK_IRQ_EN
      end else if (idx == ADDR_WIDTH'(irq_stat_idx(NUM_CTRL, NUM_STATUS))) begin
        r = REG_IRQ_STAT;
      end else if (idx == ADDR_WIDTH'(irq_mask_idx(NUM_CTRL, NUM_STATUS))) begin
        r = REG_IRQ_MASK;
`endif
      end
    end
    return r;
  endfunction

  // Address decode. The offset carries one extra bit so its MSB is the borrow
  // of ADDR - BASE_ADDR, i.e. "address below the base".
  logic [ADDR_WIDTH:0]   wr_off;
  logic [ADDR_WIDTH-1:0] wr_idx;
  region_e               wr_region;
  logic [ADDR_WIDTH:0]   rd_off;
  logic [ADDR_WIDTH-1:0] rd_idx;
  region_e               rd_region;

  always_comb begin
    wr_off    = {1'b0, WADDR} - {1'b0, BASE_ADDR};
    wr_idx    = ADDR_WIDTH'(wr_off >> 2);
    wr_region = region_of(wr_off[ADDR_WIDTH], wr_idx);
    rd_off    = {1'b0, RADDR} - {1'b0, BASE_ADDR};
    rd_idx    = ADDR_WIDTH'(rd_off >> 2);
    rd_region = region_of(rd_off[ADDR_WIDTH], rd_idx);
  end

  // Control registers and their write strobes.
  logic [DATA_WIDTH-1:0] ctrl_reg [NUM_CTRL];
  logic [NUM_CTRL-1:0]   ctrl_wr;
  logic [NUM_CTRL-1:0]   wr_strobe_reg;

  for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
    assign ctrl_wr[gi] = WEN && (wr_region == REG_CTRL) &&
                         (wr_idx == ADDR_WIDTH'(gi));
    assign CTRL_OUT[gi*DATA_WIDTH +: DATA_WIDTH] = ctrl_reg[gi];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        ctrl_reg[i] <= CTRL_RST_VAL;
      end
      wr_strobe_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (ctrl_wr[i]) begin
          ctrl_reg[i] <= WDATA;
        end
      end
      wr_strobe_reg <= ctrl_wr;
    end
  end

  assign WR_STROBE = wr_strobe_reg;

  // Write-completion counter; natural wrap at 2^DATA_WIDTH.
  logic [DATA_WIDTH-1:0] wcount_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wcount_reg <= '0;
    end else if (WACK) begin
      wcount_reg <= wcount_reg + 1'b1;
    end
  end

`ifdef NATIVE_REGBANK_IRQ_EN
  logic [DATA_WIDTH-1:0] irq_src_d_reg;
  logic [DATA_WIDTH-1:0] irq_stat_reg;
  logic [DATA_WIDTH-1:0] irq_stat_next;
  logic [DATA_WIDTH-1:0] irq_mask_reg;
  logic [DATA_WIDTH-1:0] irq_clr;
  logic                  irq_reg;

  // Set is applied after clear, so a new edge wins over a same-cycle W1C.
  always_comb begin
    irq_clr = '0;
    if (WEN && (wr_region == REG_IRQ_STAT)) begin
      irq_clr = WDATA;
    end
    irq_stat_next = (irq_stat_reg & ~irq_clr) | (IRQ_SRC & ~irq_src_d_reg);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      irq_src_d_reg <= '0;
      irq_stat_reg  <= '0;
      irq_mask_reg  <= '0;
      irq_reg       <= 1'b0;
    end else begin
      irq_src_d_reg <= IRQ_SRC;
      irq_stat_reg  <= irq_stat_next;
      if (WEN && (wr_region == REG_IRQ_MASK)) begin
        irq_mask_reg <= WDATA;
      end
      irq_reg <= |(irq_stat_reg & irq_mask_reg);
    end
  end

  assign IRQ = irq_reg;
`else
  logic unused_irq_src;
  assign unused_irq_src = ^IRQ_SRC;
  assign IRQ            = 1'b0;
`endif

  // Read mux: samples registers as they are before this cycle's write lands,
  // which gives old-value semantics for a same-index WEN/REN pair.
  logic [DATA_WIDTH-1:0] rd_data_next;

  always_comb begin
    rd_data_next = DATA_WIDTH'(UNMAPPED_VALUE);
    case (rd_region)
      REG_CTRL: begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (rd_idx == ADDR_WIDTH'(i)) begin
            rd_data_next = ctrl_reg[i];
          end
        end
      end
      REG_STATUS: begin
        for (int i = 0; i < NUM_STATUS; i++) begin
          if (rd_idx == ADDR_WIDTH'(status_base(NUM_CTRL) + i)) begin
            rd_data_next = STATUS_IN[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      REG_WCOUNT:   rd_data_next = wcount_reg;
`ifdef NATIVE_REGBANK_IRQ_EN
      REG_IRQ_STAT: rd_data_next = irq_stat_reg;
      REG_IRQ_MASK: rd_data_next = irq_mask_reg;
`endif
      default: ;
    endcase
  end

  native_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_read_pipe (
    .clk       (CLK),
    .srst      (RST),
    .push      (REN),
    .push_data (rd_data_next),
    .valid     (RVALID),
    .data      (RDATA)
  );

endmodule
